qlab5_pio_blinker: RTL and testbench
====================================

QLAB5_PIO_BLINKER -- requirements
Module: qlab5_pio_blinker

Interface
REQ-001 Parameter CNT_W, default 24, SHALL set the width of the half-period counter and the half_period input.
REQ-002 Parameter SET_ADDR, default 4, SHALL be the PIO bit-set register address.
REQ-003 Parameter CLR_ADDR, default 5, SHALL be the PIO bit-clear register address.
REQ-004 clk  in  1  SHALL be the system clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL be a one-cycle request to begin a blink sequence.
REQ-007 stop  in  1  SHALL be a one-cycle request to abort the running sequence.
REQ-008 half_period  in  CNT_W  SHALL be the high time and the low time, in clk cycles, of the PIO output.
REQ-009 pulse_count  in  8  SHALL be the number of pulses to emit; 0 means run until stop.
REQ-010 avm_address  out  3  SHALL be the Avalon-MM write address to the downstream PIO slave.
REQ-011 avm_chipselect  out  1  SHALL be the Avalon-MM chipselect.
REQ-012 avm_write_n  out  1  SHALL be the Avalon-MM active-low write strobe.
REQ-013 avm_writedata  out  32  SHALL be the Avalon-MM write data.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 done  out  1  SHALL be a one-cycle pulse on sequence completion or abort.

Function
REQ-016 States SHALL be IDLE, WR_SET, WAIT_HI, WR_CLR, WAIT_LO.
REQ-017 Write rule: the slave has no waitrequest, so each write SHALL take exactly one cycle, with avm_chipselect=1 and avm_write_n=0 only in WR_SET and WR_CLR.
REQ-018 Idle bus: outside WR_SET and WR_CLR, the outputs SHALL be avm_chipselect=0, avm_write_n=1, avm_address=0 and avm_writedata=0.
REQ-019 Set write: WR_SET SHALL drive avm_address=SET_ADDR and avm_writedata=32'h1.
REQ-020 Clear write: WR_CLR SHALL drive avm_address=CLR_ADDR and avm_writedata=32'h1.
REQ-021 Start: start sampled in IDLE SHALL latch H=max(half_period,1) and the remaining count R=pulse_count, then enter WR_SET on the next cycle.
REQ-022 Start while busy SHALL be ignored; latched H and R SHALL NOT change mid-sequence.
REQ-023 High phase: WR_SET SHALL be followed by exactly H-1 cycles of WAIT_HI, entering WR_CLR directly when H=1, so consecutive set and clear writes are exactly H cycles apart.
REQ-024 Low phase: WR_CLR SHALL be followed by exactly H-1 cycles of WAIT_LO, skipped when H=1.
REQ-025 Pulse count: R SHALL decrement by one in WR_CLR when R is nonzero at entry.
REQ-026 End of low phase, finite run: when pulse_count was nonzero and R has reached 0, the block SHALL go to IDLE and pulse done in the first IDLE cycle.
REQ-027 End of low phase, otherwise: the block SHALL re-enter WR_SET.
REQ-028 Continuous mode: with pulse_count=0, R SHALL never decrement and the sequence SHALL run until stop.
REQ-029 Stop in WR_SET or WAIT_HI: the current cycle SHALL complete, then one WR_CLR write SHALL issue, then IDLE with a done pulse.
REQ-030 Stop in WR_CLR or WAIT_LO: no further write SHALL issue; the block SHALL go to IDLE next cycle with a done pulse.
REQ-031 Stop in IDLE SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-032 Timer: the wait counter SHALL be CNT_W bits and count down, with no wrap-around at H=2^CNT_W-1.

Reset
REQ-033 Reset assertion SHALL immediately force IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, busy=0, done=0, H=1 and R=0, including mid-sequence.
REQ-034 After reset deassertion, the block SHALL stay in IDLE until start.

Verification
REQ-035 Bench SHALL cover: half_period=3, pulse_count=2, start -> set writes at cycles t+1 and t+7, clear writes at t+4 and t+10, done at t+11, busy low from t+11; the PIO model's out_port is high for 3 cycles twice.
REQ-036 Bench SHALL cover: half_period=0, pulse_count=1 -> treated as H=1; set write then clear write on consecutive cycles, then done.
REQ-037 Bench SHALL cover: pulse_count=0, H=2, stop asserted in WAIT_HI after 5 pulses -> exactly one further clear write, done pulse, no further set write, and the PIO model's out_port ends at 0.
REQ-038 Bench SHALL cover: start reasserted mid-sequence with a different half_period -> timing unchanged and the write count matches the original request.
REQ-039 Bench SHALL cover: reset_n low during WAIT_LO -> bus outputs and busy drop in the same cycle; a start after release runs a clean full sequence.
REQ-040 Bench SHALL cover: start and stop together in IDLE -> no writes and no done pulse.

Source files
------------

// File: rtl/qlab5_pio_blinker_if.sv
// Avalon-MM write-only bus from the blinker to a downstream PIO slave.
// Ports:
//   avm_address    - register address (3 bits)
//   avm_chipselect - slave select
//   avm_write_n    - active-low write strobe
//   avm_writedata  - 32-bit write data
// The blinker drives the bus through the master modport, and the PIO
// slave receives it through the slave modport.
interface qlab5_pio_blinker_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata
    );

    modport slave (
        input avm_address,
        input avm_chipselect,
        input avm_write_n,
        input avm_writedata
    );
endinterface

// File: rtl/qlab5_pio_blinker.sv
// PIO blinker. On start it toggles one PIO bit by issuing single-cycle
// Avalon-MM writes. The bit-set and bit-clear writes are spaced
// half_period cycles apart. Either pulse_count pulses are emitted, or,
// when pulse_count is 0, pulses continue until stop.
// Ports:
//   clk, reset_n  - clock; asynchronous active-low reset
//   start, stop   - one-cycle sequence request / abort
//   half_period   - high and low time in clk cycles (0 is treated as 1)
//   pulse_count   - number of pulses, 0 = run until stop
//   avm           - Avalon-MM master bus (write-only, no waitrequest)
//   busy          - high whenever the sequencer is not idle
//   done          - one-cycle pulse in the first idle cycle after a run
module qlab5_pio_blinker #(
    parameter int         CNT_W    = 24,
    parameter logic [2:0] SET_ADDR = 3'd4,
    parameter logic [2:0] CLR_ADDR = 3'd5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_W-1:0]     half_period,
    input  logic [7:0]           pulse_count,
    qlab5_pio_blinker_if.master  avm,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SET,
        WAIT_HI,
        WR_CLR,
        WAIT_LO
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] h_reg, h_next;       // latched half period, never 0
    logic [7:0]       r_reg, r_next;       // pulses remaining, 0 = continuous
    logic [CNT_W-1:0] cnt_reg, cnt_next;   // wait-phase down counter
    logic             abort_reg, abort_next;
    logic             done_reg, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            h_reg     <= ONE;
            r_reg     <= 8'd0;
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            h_reg     <= h_next;
            r_reg     <= r_next;
            cnt_reg   <= cnt_next;
            abort_reg <= abort_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        r_next     = r_reg;
        cnt_next   = cnt_reg;
        abort_next = abort_reg;

        case (state_reg)
            IDLE: begin
                abort_next = 1'b0;
                // A start that arrives together with stop is dropped.
                if (start && !stop) begin
                    h_next     = (half_period == '0) ? ONE : half_period;
                    r_next     = pulse_count;
                    state_next = WR_SET;
                end
            end

            WR_SET: begin
                if (stop) begin
                    abort_next = 1'b1;
                    state_next = WR_CLR;
                end else if (h_reg == ONE) begin
                    state_next = WR_CLR;
                end else begin
                    // The counter holds the number of wait cycles still to
                    // spend. It is loaded with H-1, so H=2^CNT_W-1 still fits.
                    cnt_next   = h_reg - ONE;
                    state_next = WAIT_HI;
                end
            end

            WAIT_HI: begin
                if (stop) begin
                    abort_next = 1'b1;
                    state_next = WR_CLR;
                end else if (cnt_reg == ONE) begin
                    state_next = WR_CLR;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end

            WR_CLR: begin
                // R == 0 here only in continuous mode. A finite run leaves
                // on the clear write that brings R to zero, so its final
                // low phase is the idle bus.
                if (r_reg != 8'd0) begin
                    r_next = r_reg - 8'd1;
                end
                if (abort_reg || stop || (r_reg == 8'd1)) begin
                    state_next = IDLE;
                end else if (h_reg == ONE) begin
                    state_next = WR_SET;
                end else begin
                    cnt_next   = h_reg - ONE;
                    state_next = WAIT_LO;
                end
            end

            WAIT_LO: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_reg == ONE) begin
                    state_next = WR_SET;
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The done pulse is registered, so it appears in the first idle cycle.
    assign done_next = (state_reg != IDLE) && (state_next == IDLE);

    // The bus is decoded from the state only. Because of this, an
    // asynchronous reset idles the bus at once.
    always_comb begin
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_address    = 3'd0;
        avm.avm_writedata  = 32'h0;
        case (state_reg)
            WR_SET: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = SET_ADDR;
                avm.avm_writedata  = 32'h1;
            end
            WR_CLR: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = CLR_ADDR;
                avm.avm_writedata  = 32'h1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: tb/tb_qlab5_pio_blinker.sv
module tb_qlab5_pio_blinker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [23:0] half_period;
    logic [7:0]  pulse_count;
    logic        busy;
    logic        done;

    qlab5_pio_blinker_if bus ();

    qlab5_pio_blinker #(
        .CNT_W    (24),
        .SET_ADDR (3'd4),
        .CLR_ADDR (3'd5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .pulse_count (pulse_count),
        .avm         (bus.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave model: the set and clear registers act on bit 0 of out_port.
    logic out_port;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= 1'b0;
        end else if (bus.avm_chipselect && !bus.avm_write_n) begin
            if (bus.avm_address == 3'd4)
                out_port <= out_port | bus.avm_writedata[0];
            else if (bus.avm_address == 3'd5)
                out_port <= out_port & ~bus.avm_writedata[0];
        end
    end

    // Bus / status monitor, sampled on the falling edge.
    int          wr_cyc[$];
    logic [2:0]  wr_addr[$];
    int          done_cyc[$];
    int          busy_fall[$];
    int          run_len[$];
    int          data_bad = 0;
    int          run_cnt = 0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(bus.avm_address);
                if (bus.avm_writedata != 32'h1) data_bad = data_bad + 1;
            end
            if (done) done_cyc.push_back(cyc);
            if (busy_prev && !busy) busy_fall.push_back(cyc);
            if (out_port) begin
                run_cnt = run_cnt + 1;
            end else if (run_cnt > 0) begin
                run_len.push_back(run_cnt);
                run_cnt = 0;
            end
        end
        busy_prev = busy;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int t0, wb, db, bb, rb;

    task automatic mark;
        wb = wr_cyc.size();
        db = done_cyc.size();
        bb = busy_fall.size();
        rb = run_len.size();
    endtask

    task automatic go(input logic [23:0] h, input logic [7:0] p);
        @(negedge clk);
        mark();
        half_period = h;
        pulse_count = p;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected pattern for half_period=3, pulse_count=2.
    task automatic check_h3p2(input string s);
        check({s, "_nwr"}, wr_cyc.size() - wb, 4);
        check({s, "_set0_t"}, wr_cyc[wb+0] - t0, 1);
        check({s, "_set0_a"}, wr_addr[wb+0], 4);
        check({s, "_clr0_t"}, wr_cyc[wb+1] - t0, 4);
        check({s, "_clr0_a"}, wr_addr[wb+1], 5);
        check({s, "_set1_t"}, wr_cyc[wb+2] - t0, 7);
        check({s, "_clr1_t"}, wr_cyc[wb+3] - t0, 10);
        check({s, "_clr1_a"}, wr_addr[wb+3], 5);
        check({s, "_ndone"}, done_cyc.size() - db, 1);
        check({s, "_done_t"}, done_cyc[db] - t0, 11);
        check({s, "_busy_t"}, busy_fall[bb] - t0, 11);
        check({s, "_nruns"}, run_len.size() - rb, 2);
        check({s, "_run0"}, run_len[rb], 3);
        check({s, "_run1"}, run_len[rb+1], 3);
    endtask

    initial begin
        int nset, nclr;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        half_period = 24'd0;
        pulse_count = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", bus.avm_chipselect, 0);
        check("rst_wrn", bus.avm_write_n, 1);
        check("rst_addr", bus.avm_address, 0);
        check("rst_data", bus.avm_writedata, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_cs", bus.avm_chipselect, 0);

        // Basic finite run.
        go(24'd3, 8'd2);
        repeat (20) @(negedge clk);
        check_h3p2("s1");
        check("s1_data", data_bad, 0);
        $display("[TB] run h=3 p=2 writes=%0d", wr_cyc.size() - wb);

        // half_period 0 is treated as 1.
        go(24'd0, 8'd1);
        repeat (10) @(negedge clk);
        check("s2_nwr", wr_cyc.size() - wb, 2);
        check("s2_set_t", wr_cyc[wb] - t0, 1);
        check("s2_set_a", wr_addr[wb], 4);
        check("s2_clr_t", wr_cyc[wb+1] - t0, 2);
        check("s2_clr_a", wr_addr[wb+1], 5);
        check("s2_done_t", done_cyc[db] - t0, 3);
        $display("[TB] run h=0 p=1 writes=%0d", wr_cyc.size() - wb);

        // Continuous run, stop in the high phase of the 6th pulse.
        go(24'd2, 8'd0);
        repeat (21) @(negedge clk);   // now in cycle t0+22 (WAIT_HI)
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (10) @(negedge clk);
        nset = 0;
        nclr = 0;
        for (int i = wb; i < wr_cyc.size(); i++) begin
            if (wr_addr[i] == 3'd4) nset++;
            if (wr_addr[i] == 3'd5) nclr++;
        end
        check("s3_nset", nset, 6);
        check("s3_nclr", nclr, 6);
        check("s3_last_t", wr_cyc[wr_cyc.size()-1] - t0, 23);
        check("s3_last_a", wr_addr[wr_addr.size()-1], 5);
        check("s3_ndone", done_cyc.size() - db, 1);
        check("s3_done_t", done_cyc[db] - t0, 24);
        check("s3_out", out_port, 0);
        check("s3_busy", busy, 0);
        $display("[TB] run h=2 p=0 stop writes=%0d", wr_cyc.size() - wb);

        // Start reasserted mid-sequence is ignored.
        go(24'd3, 8'd2);
        repeat (4) @(negedge clk);
        half_period = 24'd7;
        pulse_count = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_h3p2("s4");
        $display("[TB] run restart-ignored writes=%0d", wr_cyc.size() - wb);

        // Reset during WAIT_LO, then a clean run.
        go(24'd3, 8'd2);
        repeat (4) @(negedge clk);    // cycle t0+5 (WAIT_LO)
        check("s5_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_cs", bus.avm_chipselect, 0);
        check("s5_rst_wrn", bus.avm_write_n, 1);
        check("s5_rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        go(24'd3, 8'd2);
        repeat (20) @(negedge clk);
        check_h3p2("s5");
        $display("[TB] run after reset writes=%0d", wr_cyc.size() - wb);

        // start and stop together in IDLE.
        @(negedge clk);
        mark();
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (10) @(negedge clk);
        check("s6_nwr", wr_cyc.size() - wb, 0);
        check("s6_ndone", done_cyc.size() - db, 0);
        check("s6_busy", busy, 0);
        $display("[TB] start+stop idle writes=%0d", wr_cyc.size() - wb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
